sm_accum_ctrl: RTL
==================

Name: sm_accum_ctrl

Overview:
Sequencing controller for the decoder's 32-bit sign-magnitude fixed-point adder (bit 31 = sign, bits 30:0 = magnitude).
- Accumulates a fixed-length stream of N_TERMS operands onto a bias using one internal adder instance.
- Uses valid/ready handshakes on input and output.
- Sits between the decoder weight-product stream and the activation stage; produces one neuron pre-activation sum per start.

Parameters:
N_TERMS, 8, number of operands accumulated per start (>=1).
CNT_W, 4, term counter width; must satisfy 2^CNT_W > N_TERMS.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous active-high reset.
start  input  1  begin accumulation; sampled only in IDLE.
bias  input  32  sign-magnitude initial accumulator value; latched on accepted start.
in_valid  input  1  operand valid.
in_data  input  32  sign-magnitude operand.
in_ready  output  1  operand accepted when in_valid&&in_ready.
out_valid  output  1  result valid.
out_data  output  32  accumulated sign-magnitude result.
out_ready  input  1  result consumed when out_valid&&out_ready.
busy  output  1  high in ACCUM or DONE.
ovf  output  1  sticky magnitude-overflow flag for the current result.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, acc=0, count=0, in_ready=0, out_valid=0, out_data=0, busy=0, ovf=0.
- rst asserted mid-operation: abandons the accumulation at the next edge; all operands in flight are discarded.
- Adder rule, add(a,b):
  - Same signs: magnitude = (|a|+|b|) mod 2^31, sign = sign of a. Carry out of bit 30 sets ovf.
  - Different signs: magnitude = larger − smaller, sign = sign of the larger magnitude. Equal magnitudes give zero.
  - Zero magnitude always forces sign 0 (no negative zero).
- Sign-magnitude normalization: an input of 0x80000000 is treated as zero.
- IDLE:
  - in_ready=0, busy=0.
  - On start: acc<=bias (normalised, 0x80000000 -> 0x00000000), count<=0, ovf<=0, go to ACCUM.
- ACCUM:
  - in_ready=1, busy=1. start is ignored.
  - On handshake: acc<=add(acc,in_data), count<=count+1.
  - Handshake while count==N_TERMS-1: go to DONE.
  - in_valid low: hold state; gaps of any length are allowed.
- DONE:
  - in_ready=0, out_valid=1, out_data=acc, busy=1.
  - Hold all outputs stable until out_ready. On handshake: out_valid<=0, go to IDLE.
- Latency: out_valid asserts the cycle after the final operand handshake. Minimum start-to-result time is N_TERMS+1 cycles.
- out_ready high when entering DONE: DONE lasts exactly one cycle.
- A start in the same cycle as the DONE->IDLE transition is ignored. The next start is accepted from IDLE, so back-to-back throughput is N_TERMS+2 cycles.
- ovf is sticky across the accumulation: once set it stays high until the next accepted start or rst. It is valid alongside out_valid.
- Count never wraps: count ranges 0..N_TERMS-1.

Test Plan:
- N_TERMS=4, bias=0x00000000, operands 0x00000005, 0x80000003, 0x00000002, 0x80000004 streamed back-to-back -> out_valid on cycle 5 after start, out_data=0x00000000 (sign cleared), ovf=0.
- N_TERMS=8, bias=0x80000001, eight operands of 0x00000001 with in_valid low on alternate cycles -> out_data=0x00000007. in_ready stays high throughout ACCUM. Exactly 8 handshakes occur.
- N_TERMS=4, bias=0x7FFFFFFF, operands 0x00000001, then three of 0x00000000 -> out_data=0x00000000, ovf=1. A following start with bias 0 clears ovf to 0.
- Output backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, a start pulse is ignored. Then out_ready=1 -> IDLE next cycle.
- Assert rst after 2 of 4 operands accepted -> next cycle all outputs at reset values. A new start with bias 0x00000003 and 4 operands of 0x80000001 -> out_data=0x80000001.
- Assert start while in ACCUM with a different bias -> no effect; the result uses the originally latched bias.

Source files
------------

// File: rtl/sm_accum_ctrl.sv
// Sequencing controller that accumulates N_TERMS sign-magnitude operands onto a
// latched bias through one sign-magnitude adder, with valid/ready on both sides.
module sm_accum_ctrl #(
  parameter int N_TERMS = 8,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bias,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        ovf
);

  localparam int DATA_W = 32;
  localparam int MAG_W  = DATA_W - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   acc;
  logic [CNT_W-1:0]    count;
  logic [DATA_W:0]     add_res;
  logic                in_hs;

  // Negative zero is folded to +0 so it can never reach the accumulator.
  function automatic logic [DATA_W-1:0] sm_norm(input logic [DATA_W-1:0] x);
    return (x[MAG_W-1:0] == '0) ? '0 : x;
  endfunction

  // Returns {carry_out, sign, magnitude}; carry is only possible for like signs.
  function automatic logic [DATA_W:0] sm_add(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [MAG_W-1:0] ma, mb, mag;
    logic [MAG_W:0]   sum;
    logic             sa, sb, sgn, cy;
    ma  = a[MAG_W-1:0];
    mb  = b[MAG_W-1:0];
    sa  = a[DATA_W-1] && (ma != '0);
    sb  = b[DATA_W-1] && (mb != '0);
    sum = {1'b0, ma} + {1'b0, mb};
    cy  = 1'b0;
    if (sa == sb) begin
      mag = sum[MAG_W-1:0];
      cy  = sum[MAG_W];
      sgn = sa;
    end else if (ma >= mb) begin
      mag = ma - mb;
      sgn = sa;
    end else begin
      mag = mb - ma;
      sgn = sb;
    end
    if (mag == '0) sgn = 1'b0;
    return {cy, sgn, mag};
  endfunction

  assign add_res = sm_add(acc, in_data);
  assign in_hs   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= sm_norm(bias);
            count    <= '0;
            ovf      <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_hs) begin
            acc <= add_res[DATA_W-1:0];
            ovf <= ovf | add_res[DATA_W];
            if (count == LAST_CNT) begin
              count     <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= add_res[DATA_W-1:0];
              state     <= DONE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
